// File: rtl/fact_pkg.sv
// Shared types and constants for the iterative factorial / falling-factorial engine.
package fact_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } fact_state_t;

    localparam logic MODE_FACT = 1'b0;
    localparam logic MODE_PERM = 1'b1;

    // Widest operand supported; the error pattern for a given WIDTH is ALL_ONES[WIDTH-1:0].
    localparam int                   MAX_WIDTH = 256;
    localparam logic [MAX_WIDTH-1:0] ALL_ONES  = '1;

endpackage

// File: rtl/fact_engine_if.sv
// Request/result bundle between the register wrapper (master) and fact_engine (slave).
// The cycles signal only exists when FACT_ENGINE_CYCLES_EN is defined.
interface fact_engine_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic             go;
    logic             mode;
    logic [WIDTH-1:0] n;
    logic [WIDTH-1:0] k;
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] result;
`ifdef FACT_ENGINE_CYCLES_EN
    logic [CNT_W-1:0] cycles;
`endif

    modport master (
        output go, mode, n, k,
`ifdef FACT_ENGINE_CYCLES_EN
        input  cycles,
`endif
        input  busy, done, err, result
    );

    modport slave (
        input  go, mode, n, k,
`ifdef FACT_ENGINE_CYCLES_EN
        output cycles,
`endif
        output busy, done, err, result
    );

endinterface

// File: rtl/fact_mul_chk.sv
// Combinational WIDTH x WIDTH multiply returning the low half and an upper-half-nonzero flag.
// Kept separate so a pipelined multiplier can replace it without touching the FSM.
module fact_mul_chk #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_lo,
    output logic             o_ovf
);
    logic [2*WIDTH-1:0] w_prod;

    assign w_prod = {{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b};
    assign o_lo   = w_prod[WIDTH-1:0];
    assign o_ovf  = |w_prod[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/fact_engine.sv
// Iterative n! / P(n,k) engine, one multiply per cycle; done rises m+2 edges after go is sampled.
// go is ignored while busy; optional CALC-cycle counter under FACT_ENGINE_CYCLES_EN.
module fact_engine
    import fact_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic         clk,
    input  logic         rst,
    fact_engine_if.slave bus
);
    localparam logic [WIDTH-1:0] ERR_VAL = ALL_ONES[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

    generate
        if (WIDTH < 4 || WIDTH > MAX_WIDTH || CNT_W < 1) begin : g_bad_param
            $error("fact_engine: unsupported WIDTH/CNT_W");
        end
    endgenerate

    fact_state_t      r_state, w_state_n;
    logic [WIDTH-1:0] r_p, w_p_n;
    logic [WIDTH-1:0] r_c, w_c_n;
    logic [WIDTH-1:0] r_r, w_r_n;
    logic             r_busy, w_busy_n;
    logic             r_done, w_done_n;
    logic             r_err, w_err_n;
    logic [WIDTH-1:0] r_result, w_result_n;

    // Accepted request, acted on at the following edge.
    logic             r_go_q;
    logic             r_mode_q, w_mode_q_n;
    logic [WIDTH-1:0] r_n_q, w_n_q_n;
    logic [WIDTH-1:0] r_k_q, w_k_q_n;

    logic             w_accept;
    logic [WIDTH-1:0] w_lo;
    logic             w_ovf;

    fact_mul_chk #(.WIDTH(WIDTH)) u_mul (
        .i_a   (r_p),
        .i_b   (r_c),
        .o_lo  (w_lo),
        .o_ovf (w_ovf)
    );

    assign w_accept = bus.go && (r_state != CALC) && !r_go_q;

    always_comb begin
        w_state_n  = r_state;
        w_p_n      = r_p;
        w_c_n      = r_c;
        w_r_n      = r_r;
        w_busy_n   = r_busy;
        w_done_n   = r_done;
        w_err_n    = r_err;
        w_result_n = r_result;
        w_mode_q_n = w_accept ? bus.mode : r_mode_q;
        w_n_q_n    = w_accept ? bus.n    : r_n_q;
        w_k_q_n    = w_accept ? bus.k    : r_k_q;

        if (r_go_q) begin
            w_p_n      = ONE;
            w_c_n      = r_n_q;
            w_r_n      = (r_mode_q == MODE_PERM) ? r_k_q : r_n_q;
            w_done_n   = 1'b0;
            w_err_n    = 1'b0;
            w_result_n = '0;
            if (r_mode_q == MODE_PERM && r_k_q > r_n_q) begin
                w_state_n  = ERR;
                w_err_n    = 1'b1;
                w_result_n = ERR_VAL;
                w_busy_n   = 1'b0;
            end else begin
                w_state_n = CALC;
                w_busy_n  = 1'b1;
            end
        end else if (r_state == CALC) begin
            if (r_r == '0) begin
                w_result_n = r_p;
                w_done_n   = 1'b1;
                w_busy_n   = 1'b0;
                w_state_n  = DONE;
            end else if (w_ovf) begin
                w_result_n = ERR_VAL;
                w_err_n    = 1'b1;
                w_busy_n   = 1'b0;
                w_state_n  = ERR;
            end else begin
                // r <= n guarantees c >= 1 here, so c never wraps.
                w_p_n = w_lo;
                w_c_n = r_c - ONE;
                w_r_n = r_r - ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_p      <= ONE;
            r_c      <= '0;
            r_r      <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_result <= '0;
            r_go_q   <= 1'b0;
            r_mode_q <= MODE_FACT;
            r_n_q    <= '0;
            r_k_q    <= '0;
        end else begin
            r_state  <= w_state_n;
            r_p      <= w_p_n;
            r_c      <= w_c_n;
            r_r      <= w_r_n;
            r_busy   <= w_busy_n;
            r_done   <= w_done_n;
            r_err    <= w_err_n;
            r_result <= w_result_n;
            r_go_q   <= w_accept;
            r_mode_q <= w_mode_q_n;
            r_n_q    <= w_n_q_n;
            r_k_q    <= w_k_q_n;
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.err    = r_err;
    assign bus.result = r_result;

`ifdef FACT_ENGINE_CYCLES_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_cycles, w_cycles_n;

    always_comb begin
        w_cycles_n = r_cycles;
        if (r_go_q) begin
            w_cycles_n = '0;
        end else if (r_state == CALC && r_cycles != '1) begin
            w_cycles_n = r_cycles + CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cycles <= '0;
        end else begin
            r_cycles <= w_cycles_n;
        end
    end

    assign bus.cycles = r_cycles;
`endif

endmodule

// File: tb/tb_fact_engine.sv
// Directed bench for fact_engine (WIDTH=32); checks cycles when FACT_ENGINE_CYCLES_EN is defined.
module tb_fact_engine;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_cmp = 0;
    int n_err = 0;
    int edges;
    int busy_cnt;

    fact_engine_if #(.WIDTH(32), .CNT_W(16)) bus ();

    fact_engine #(.WIDTH(32), .CNT_W(16)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse go for one sampling edge; returns #1 after that edge.
    task automatic start(input logic m, input logic [31:0] nv, input logic [31:0] kv);
        @(negedge clk);
        bus.go   = 1'b1;
        bus.mode = m;
        bus.n    = nv;
        bus.k    = kv;
        @(posedge clk);
        #1;
        bus.go = 1'b0;
    endtask

    // Counts edges after the go-sampling edge until done or err, with a bound.
    task automatic wait_end(output int e, output int b);
        e = 0;
        b = 0;
        do begin
            @(posedge clk);
            #1;
            e++;
            if (bus.busy === 1'b1) b++;
        end while (!(bus.done === 1'b1 || bus.err === 1'b1) && e < 300);
    endtask

    initial begin
        bus.go   = 1'b0;
        bus.mode = 1'b0;
        bus.n    = '0;
        bus.k    = '0;

        #1;
        chk("rst_busy",   bus.busy,   0);
        chk("rst_done",   bus.done,   0);
        chk("rst_err",    bus.err,    0);
        chk("rst_result", bus.result, 0);
`ifdef FACT_ENGINE_CYCLES_EN
        chk("rst_cycles", bus.cycles, 0);
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // 5! : busy 6 cycles, done 7 edges after go
        start(1'b0, 32'd5, 32'd0);
        chk("f5_busy_early", bus.busy, 0);
        wait_end(edges, busy_cnt);
        chk("f5_edges",  edges,      7);
        chk("f5_busycnt", busy_cnt,  6);
        chk("f5_result", bus.result, 120);
        chk("f5_done",   bus.done,   1);
        chk("f5_err",    bus.err,    0);
`ifdef FACT_ENGINE_CYCLES_EN
        chk("f5_cycles", bus.cycles, 6);
`endif

        // 12! fits, 13! overflows 32 bits
        start(1'b0, 32'd12, 32'd0);
        wait_end(edges, busy_cnt);
        chk("f12_result", bus.result, 479001600);
        chk("f12_done",   bus.done,   1);
        start(1'b0, 32'd13, 32'd0);
        wait_end(edges, busy_cnt);
        chk("f13_err",    bus.err,    1);
        chk("f13_result", bus.result, 32'hFFFF_FFFF);
        chk("f13_done",   bus.done,   0);
        chk("f13_busy",   bus.busy,   0);

        // P(10,3) = 720, done 5 edges after go; P(3,5) invalid
        start(1'b1, 32'd10, 32'd3);
        wait_end(edges, busy_cnt);
        chk("p10_3_edges",  edges,      5);
        chk("p10_3_result", bus.result, 720);
        chk("p10_3_err",    bus.err,    0);
        start(1'b1, 32'd3, 32'd5);
        wait_end(edges, busy_cnt);
        chk("p3_5_edges",   edges,      1);
        chk("p3_5_err",     bus.err,    1);
        chk("p3_5_busycnt", busy_cnt,   0);
        chk("p3_5_done",    bus.done,   0);
`ifdef FACT_ENGINE_CYCLES_EN
        chk("p3_5_cycles",  bus.cycles, 0);
`endif

        // Zero-length products
        start(1'b0, 32'd0, 32'd0);
        wait_end(edges, busy_cnt);
        chk("f0_edges",  edges,      2);
        chk("f0_result", bus.result, 1);
        start(1'b1, 32'd7, 32'd0);
        wait_end(edges, busy_cnt);
        chk("p7_0_edges",  edges,      2);
        chk("p7_0_result", bus.result, 1);
        chk("p7_0_done",   bus.done,   1);

        // go during CALC is dropped; go in DONE restarts
        start(1'b0, 32'd10, 32'd0);
        repeat (3) @(posedge clk);
        start(1'b0, 32'd3, 32'd0);
        chk("mid_busy", bus.busy, 1);
        wait_end(edges, busy_cnt);
        chk("f10_result", bus.result, 3628800);
        start(1'b0, 32'd4, 32'd0);
        @(posedge clk);
        #1;
        chk("restart_done_drop", bus.done, 0);
        chk("restart_busy",      bus.busy, 1);
        wait_end(edges, busy_cnt);
        chk("f4_result", bus.result, 24);

        // Asynchronous reset mid-CALC
        start(1'b0, 32'd8, 32'd0);
        repeat (3) @(posedge clk);
        #3;
        chk("pre_rst_busy", bus.busy, 1);
        rst = 1'b1;
        #1;
        chk("arst_busy",   bus.busy,   0);
        chk("arst_done",   bus.done,   0);
        chk("arst_err",    bus.err,    0);
        chk("arst_result", bus.result, 0);
`ifdef FACT_ENGINE_CYCLES_EN
        chk("arst_cycles", bus.cycles, 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        start(1'b0, 32'd4, 32'd0);
        wait_end(edges, busy_cnt);
        chk("post_rst_edges",  edges,      6);
        chk("post_rst_result", bus.result, 24);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fact_engine.md
Name: fact_engine

Overview:
- Parametrised successor to the team's go/done factorial unit.
- Computes n! or the falling factorial P(n,k) = n!/(n-k)! iteratively, one multiply per cycle.
- Overflow is detected from the actual product width, not a fixed input limit.
- Sits on the SoC peripheral side as a memory-mapped accelerator behind a register wrapper.

Parameters:
- WIDTH, 32, operand/result width in bits (min 4).
- CNT_W, 16, width of cycle counter (used only with FACT_ENGINE_CYCLES_EN).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; asynchronous and active-high.
- go  input  1  start request, sampled on clk.
- mode  input  1  0 = factorial n!, 1 = permutation P(n,k).
- n  input  WIDTH  operand n.
- k  input  WIDTH  operand k (ignored when mode=0).
- busy  output  1  high while computing.
- done  output  1  result valid, held until the next accepted go.
- err  output  1  overflow or invalid operands, held until the next accepted go.
- result  output  WIDTH  product; all-ones on err.
- cycles  output  CNT_W  CALC cycles of the last operation (only with FACT_ENGINE_CYCLES_EN).

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, err=0, result=0, cycles=0; internal P=1, c=0, r=0.
- States: IDLE, CALC, DONE, ERR.
- Accept rule: go is accepted in IDLE, DONE or ERR. go during CALC is ignored, no queueing.
- On acceptance, the next edge:
  - Latches n, k, mode.
  - Sets P=1, c=n, r = (mode ? k : n).
  - Clears done, err and result.
  - If mode=1 and k>n: state goes directly to ERR (err=1 one edge after go).
  - Otherwise: state=CALC, busy=1.
- CALC, each cycle:
  - If r==0: result<=P[WIDTH-1:0], done<=1, busy<=0, state<=DONE.
  - Else: compute full 2*WIDTH product P*c.
    - If the upper WIDTH bits are nonzero: err<=1, result<=all-ones, busy<=0, state<=ERR.
    - Otherwise: P<=low half, c<=c-1, r<=r-1.
- Latency, where m = r at start (n for factorial, k for permutation): done rises m+2 edges after the edge that sampled go.
  - 0! and P(n,0) give result=1, done 2 edges after go.
- c never underflows: r<=n is guaranteed, so c>=1 whenever a multiply occurs.
- DONE/ERR: outputs held stable; a new go restarts as above (back-to-back operation allowed).
- Unsigned arithmetic throughout.

Optional Feature:
- Macro: FACT_ENGINE_CYCLES_EN.
- Defined:
  - cycles port exists.
  - Counter clears on accepted go and increments each CALC cycle, saturating at all-ones.
  - Counter holds in DONE/ERR; reset to 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package fact_pkg holds:
  - state enum (IDLE, CALC, DONE, ERR);
  - mode constants MODE_FACT=1'b0, MODE_PERM=1'b1;
  - localparam for the all-ones error value as a function of WIDTH.
- Sub-module fact_mul_chk:
  - combinational WIDTH x WIDTH multiplier;
  - outputs the low WIDTH bits and an ovf flag (upper half nonzero);
  - keeps the FSM/datapath clean and is swappable for a pipelined multiplier later.

Test Plan:
1. WIDTH=32, mode=0, n=5, go pulse -> busy for 6 cycles, done rises 7 edges after go, result=120, err=0; with macro, cycles=6.
2. mode=0, n=12 -> result=479001600, done. Then n=13 -> err=1, result=0xFFFFFFFF, done=0, busy=0.
3. mode=1, n=10, k=3 -> result=720, done 5 edges after go. Then mode=1, n=3, k=5 -> err=1 one edge after go, no CALC cycles.
4. mode=0, n=0, and separately mode=1, n=7, k=0 -> result=1, done 2 edges after go.
5. Start n=10. Pulse go again mid-CALC with n=3 -> ignored, result=3628800. Then go with n=4 while in DONE -> done drops next edge, result=24.
6. Assert rst asynchronously mid-CALC (n=8) -> all outputs 0 immediately without a clock edge. After release, go with n=4 -> result=24.
